// File: rtl/rosco_dtack.sv
// rosco_dtack: bus-cycle termination stage with per-region wait states,
// external acknowledge pass-through and a BERRn watchdog.
module rosco_dtack #(
   parameter int ROM_WS    = 3,
   parameter int RAM_WS    = 0,
   parameter int EXP_WS    = 2,
   parameter int WD_CYCLES = 128
) (
   input  logic CLK,
   input  logic RESETn,
   input  logic ASn,
   input  logic ROMSELn,
   input  logic RAMSELn,
   input  logic EXPSELn,
   input  logic IOSELn,
   input  logic CPUSPn,
   input  logic EXTDTACKn,
   output logic DTACKn,
   output logic BERRn,
   output logic BUSY
);
   typedef enum logic [2:0] {IDLE, WAIT, EXTW, ACK, ERR} state_t;
   typedef enum logic [2:0] {C_ROM, C_RAM, C_EXP, C_IO, C_CPU, C_NONE} cls_t;
   localparam logic [7:0] WD_LAST = 8'(WD_CYCLES - 1);
   state_t     state;
   cls_t       cls;
   logic [3:0] ws_cnt, ws_load;
   logic [7:0] wd_cnt;
   logic       ext_q, internal, ack, wd_hit;
   always_comb begin
      cls      = !CPUSPn  ? C_CPU :
                 !ROMSELn ? C_ROM :
                 !RAMSELn ? C_RAM :
                 !EXPSELn ? C_EXP :
                 !IOSELn  ? C_IO  : C_NONE;
      internal = cls == C_ROM || cls == C_RAM || cls == C_EXP;
      ws_load  = cls == C_ROM ? 4'(ROM_WS) : cls == C_RAM ? 4'(RAM_WS) : 4'(EXP_WS);
      ack      = state == WAIT ? ws_cnt == 4'd0 : state == EXTW && !ext_q;
      wd_hit   = wd_cnt == WD_LAST;
   end
   // ext_q gives the external acknowledge its one-cycle registration delay
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state  <= IDLE;
         ws_cnt <= 4'd0;
         wd_cnt <= 8'd0;
         ext_q  <= 1'b1;
         DTACKn <= 1'b1;
         BERRn  <= 1'b1;
         BUSY   <= 1'b0;
      end else begin
         ext_q <= EXTDTACKn;
         case (state)
            IDLE: if (!ASn) begin
               state  <= internal ? WAIT : EXTW;
               ws_cnt <= internal ? ws_load : 4'd0;
               wd_cnt <= 8'd0;
               BUSY   <= 1'b1;
            end
            WAIT, EXTW: begin
               wd_cnt <= wd_cnt + {7'd0, wd_cnt != 8'hFF};
               if (ASn) begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end else if (ack) begin
                  state  <= ACK;
                  DTACKn <= 1'b0;
               end else if (wd_hit) begin
                  state <= ERR;
                  BERRn <= 1'b0;
               end else if (state == WAIT) begin
                  ws_cnt <= ws_cnt - 4'd1;
               end
            end
            ACK: if (ASn) begin
               state  <= IDLE;
               DTACKn <= 1'b1;
               BUSY   <= 1'b0;
            end
            ERR: if (ASn) begin
               state <= IDLE;
               BERRn <= 1'b1;
               BUSY  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rosco_dtack.sv
// tb_rosco_dtack: scoreboard of expected output transitions (edge, signal, level)
// for the default instance, plus direct checks on a WD_CYCLES=5 instance.
module tb_rosco_dtack;
   logic CLK = 1'b0, RESETn = 1'b0, ASn = 1'b1;
   logic ROMSELn = 1'b1, RAMSELn = 1'b1, EXPSELn = 1'b1, IOSELn = 1'b1, CPUSPn = 1'b1;
   logic EXTDTACKn = 1'b1;
   logic DTACKn, BERRn, BUSY, dtack5, berr5, busy5;
   int cyc = 0, n_chk = 0, n_err = 0, n0 = 0;
   int q[$];
   bit mon_on = 1'b0;
   logic [2:0] prv = 3'b011;

   // select vectors: {CPUSPn, ROMSELn, RAMSELn, EXPSELn, IOSELn}
   localparam logic [4:0] S_ROM = 5'b10111, S_RAM = 5'b11011, S_EXP = 5'b11101;
   localparam logic [4:0] S_IO = 5'b11110, S_NONE = 5'b11111;
   localparam logic [4:0] S_CPUROM = 5'b00111, S_ROMRAM = 5'b10011;
   localparam int DT = 0, BE = 1, BZ = 2;

   rosco_dtack dut (
      .CLK(CLK), .RESETn(RESETn), .ASn(ASn), .ROMSELn(ROMSELn), .RAMSELn(RAMSELn),
      .EXPSELn(EXPSELn), .IOSELn(IOSELn), .CPUSPn(CPUSPn), .EXTDTACKn(EXTDTACKn),
      .DTACKn(DTACKn), .BERRn(BERRn), .BUSY(BUSY)
   );
   rosco_dtack #(.WD_CYCLES(5)) dut5 (
      .CLK(CLK), .RESETn(RESETn), .ASn(ASn), .ROMSELn(ROMSELn), .RAMSELn(RAMSELn),
      .EXPSELn(EXPSELn), .IOSELn(IOSELn), .CPUSPn(CPUSPn), .EXTDTACKn(EXTDTACKn),
      .DTACKn(dtack5), .BERRn(berr5), .BUSY(busy5)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // events are encoded as edge*8 + signal*2 + level
   always @(negedge CLK) begin
      logic [2:0] cur;
      cur = {BUSY, BERRn, DTACKn};
      if (mon_on)
         for (int s = 0; s < 3; s++)
            if (cur[s] !== prv[s]) begin
               if (q.size() == 0) check("unexpected_event", cyc * 8 + s * 2 + int'(cur[s]), -1);
               else check("event", cyc * 8 + s * 2 + int'(cur[s]), q.pop_front());
            end
      prv = cur;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge CLK);
   endtask

   task automatic push(input int e, input int s, input int v);
      q.push_back(e * 8 + s * 2 + v);
   endtask

   task automatic start(input logic [4:0] sel);
      {CPUSPn, ROMSELn, RAMSELn, EXPSELn, IOSELn} = sel;
      ASn = 1'b0;
      n0 = cyc + 1;
      push(n0, BZ, 1);
      tick();
   endtask

   task automatic release_as(input bit dt, input bit be);
      int e;
      ASn = 1'b1;
      e = cyc + 1;
      if (dt) push(e, DT, 1);
      if (be) push(e, BE, 1);
      push(e, BZ, 0);
      tick();
      {CPUSPn, ROMSELn, RAMSELn, EXPSELn, IOSELn} = S_NONE;
      tick();
   endtask

   initial begin
      tick(2);
      check("rst_dtack", DTACKn, 1);
      check("rst_berr", BERRn, 1);
      check("rst_busy", BUSY, 0);
      RESETn = 1'b1;
      tick();
      mon_on = 1'b1;

      // ROM (3 WS) then RAM (0 WS) then EXP (2 WS), back to back
      start(S_ROM);  push(n0 + 4, DT, 0); tick(6); release_as(1, 0);
      start(S_RAM);  push(n0 + 1, DT, 0); tick(3); release_as(1, 0);
      start(S_EXP);  push(n0 + 3, DT, 0); tick(5); release_as(1, 0);
      // ROM outranks RAM
      start(S_ROMRAM); push(n0 + 4, DT, 0); tick(5); release_as(1, 0);

      // IO: EXTDTACKn sampled low at N+6 -> DTACKn low after N+7, held while ASn low
      start(S_IO);
      push(n0 + 7, DT, 0);
      tick(5);
      EXTDTACKn = 1'b0;
      tick();
      EXTDTACKn = 1'b1;
      tick(6);
      release_as(1, 0);

      // CPU space outranks ROM: needs the external acknowledge
      start(S_CPUROM);
      push(n0 + 3, DT, 0);
      tick();
      EXTDTACKn = 1'b0;
      tick();
      EXTDTACKn = 1'b1;
      tick(4);
      release_as(1, 0);

      // unmapped: watchdog at N+128 (and N+5 on the short-watchdog instance)
      start(S_NONE);
      push(n0 + 128, BE, 0);
      for (int i = 1; i < 200; i++) begin
         tick();
         if (cyc == n0 + 4) check("wd5_early", berr5, 1);
         if (cyc == n0 + 5) check("wd5_expire", berr5, 0);
         if (cyc == n0 + 5) check("wd5_no_dtack", dtack5, 1);
      end
      release_as(0, 1);

      // race on WD_CYCLES=5: acknowledge reaches the FSM on the expiry edge N+5
      start(S_IO);
      push(n0 + 5, DT, 0);
      tick(3);
      EXTDTACKn = 1'b0;
      tick();
      EXTDTACKn = 1'b1;
      tick();
      check("race_dtack", dtack5, 0);
      check("race_berr", berr5, 1);
      tick(3);
      check("race_berr_hold", berr5, 1);
      check("race_dtack_hold", dtack5, 0);
      release_as(1, 0);

      // abort: ASn released so that edge N+2 samples it high
      start(S_ROM);
      tick();
      ASn = 1'b1;
      push(n0 + 2, BZ, 0);
      tick(6);
      {CPUSPn, ROMSELn, RAMSELn, EXPSELn, IOSELn} = S_NONE;
      start(S_RAM); push(n0 + 1, DT, 0); tick(2); release_as(1, 0);

      // asynchronous reset two cycles into a ROM wait
      start(S_ROM);
      tick(2);
      mon_on = 1'b0;
      check("pre_rst_busy", BUSY, 1);
      #2 RESETn = 1'b0;
      #1;
      check("async_rst_dtack", DTACKn, 1);
      check("async_rst_berr", BERRn, 1);
      check("async_rst_busy", BUSY, 0);
      tick();
      ASn = 1'b1;
      {CPUSPn, ROMSELn, RAMSELn, EXPSELn, IOSELn} = S_NONE;
      RESETn = 1'b1;
      tick(2);
      mon_on = 1'b1;
      start(S_EXP); push(n0 + 3, DT, 0); tick(4); release_as(1, 0);

      tick(2);
      check("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
